// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Shares one byte-wide RAM port between instruction fetch (IF)    |
// |            and the load/store stage (MEM). Every request is a 32-bit       |
// |            transaction of 1-4 little-endian byte accesses. MEM wins when   |
// |            both ask in IDLE. A PC redirect (if_flush_i) aborts an IF read. |
// | Ports    : clk, rst (async, active low)                                    |
// |            if_req_i/if_addr_i/if_flush_i -> if_data_o/if_done_o            |
// |            mem_req_i/mem_we_i/mem_len_i/mem_addr_i/mem_wdata_i             |
// |              -> mem_rdata_o/mem_done_o                                     |
// |            ram_addr_o/ram_wr_o/ram_dout_o -> RAM, ram_din_i <- RAM         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int RD_LAT = 1            // address-to-read-data latency, 1..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IF_RD  = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_rdata;
  logic [2:0]  r_len;
  logic [2:0]  r_cnt;
  logic        r_is_if;

  // Read-return tags: one stage per cycle of RAM latency. A tag says which
  // byte lane the RAM data emerging from the last stage belongs to.
  logic        r_tag_v   [RD_LAT];
  logic [1:0]  r_tag_idx [RD_LAT];

  logic        w_rd_state;
  logic        w_phase;
  logic        w_flush;
  logic        w_ret_v;
  logic [1:0]  w_ret_idx;
  logic        w_ret_last;
  logic [2:0]  w_mem_len;
  logic [31:0] w_buf_nxt;

  assign w_rd_state = (r_state == S_IF_RD) || (r_state == S_MEM_RD);
  assign w_phase    = (w_rd_state || (r_state == S_MEM_WR)) && (r_cnt < r_len);
  assign w_flush    = (r_state == S_IF_RD) && if_flush_i;
  assign w_ret_v    = r_tag_v[RD_LAT-1];
  assign w_ret_idx  = r_tag_idx[RD_LAT-1];
  assign w_ret_last = w_ret_v && ({1'b0, w_ret_idx} == (r_len - 3'd1));

  always_comb begin
    w_mem_len = 3'd4;
    case (mem_len_i)
      2'b00:   w_mem_len = 3'd1;
      2'b01:   w_mem_len = 3'd2;
      default: w_mem_len = 3'd4;
    endcase
  end

  // Read buffer with the byte returning this cycle already merged, so the
  // final byte can go straight into the output register on the DONE edge.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_ret_v) begin
      w_buf_nxt[{w_ret_idx, 3'b000} +: 8] = ram_din_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_state_nxt = mem_we_i ? S_MEM_WR : S_MEM_RD;
        end else if (if_req_i && !if_flush_i) begin
          w_state_nxt = S_IF_RD;
        end
      end
      S_IF_RD, S_MEM_RD: begin
        if (w_flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_ret_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_MEM_WR: begin
        if (r_cnt == (r_len - 3'd1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_is_if     <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_idx[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && (w_state_nxt != S_IDLE)) begin
        r_base  <= mem_req_i ? mem_addr_i : if_addr_i;
        r_len   <= mem_req_i ? w_mem_len : 3'd4;
        r_wdata <= mem_wdata_i;
        r_is_if <= !mem_req_i;
        r_cnt   <= '0;
        r_buf   <= '0;
      end else if (w_phase) begin
        r_cnt <= r_cnt + 3'd1;
      end

      if (w_rd_state && !w_flush) begin
        r_buf <= w_buf_nxt;
      end

      if (w_rd_state && (w_state_nxt == S_DONE)) begin
        if (r_is_if) begin
          r_if_data <= w_buf_nxt;
        end else begin
          r_mem_rdata <= w_buf_nxt;
        end
      end

      // A flush kills every tag in flight so late bytes never land.
      r_tag_v[0]   <= w_phase && w_rd_state && !w_flush;
      r_tag_idx[0] <= r_cnt[1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1] && !w_flush;
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  assign ram_addr_o  = w_phase ? (r_base + {29'd0, r_cnt}) : 32'd0;
  assign ram_wr_o    = w_phase && (r_state == S_MEM_WR);
  assign ram_dout_o  = ram_wr_o ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;
  assign if_done_o   = (r_state == S_DONE) && r_is_if;
  assign mem_done_o  = (r_state == S_DONE) && !r_is_if;
  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                  |
// | Purpose  : Self-checking bench for mem_arbiter. A byte RAM model answers   |
// |            reads with the configured latency; expected address phases and |
// |            done pulses are queued when stimulus is applied and popped as   |
// |            each captured cycle is compared.                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, mem_req_i, mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
  logic        if_done_o, mem_done_o, ram_wr_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  // second instance, RD_LAT=2, used only for the latency-2 load
  logic        m2_req;
  logic [31:0] m2_addr;
  logic [31:0] d2_if_data, d2_mrdata, d2_addr;
  logic        d2_if_done, d2_mdone, d2_wr;
  logic [7:0]  d2_dout, d2_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  mem_arbiter #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'd0), .if_flush_i(1'b0),
    .if_data_o(d2_if_data), .if_done_o(d2_if_done),
    .mem_req_i(m2_req), .mem_we_i(1'b0), .mem_len_i(2'b01),
    .mem_addr_i(m2_addr), .mem_wdata_i(32'd0),
    .mem_rdata_o(d2_mrdata), .mem_done_o(d2_mdone),
    .ram_addr_o(d2_addr), .ram_wr_o(d2_wr), .ram_dout_o(d2_dout),
    .ram_din_i(d2_din)
  );

  // RAM model: 4 KiB, low 12 address bits, registered read data.
  logic [7:0] mem [4096];
  logic [7:0] rd2a;
  always @(posedge clk) begin
    ram_din_i <= mem[ram_addr_o[11:0]];
    rd2a      <= mem[d2_addr[11:0]];
    d2_din    <= rd2a;
    if (ram_wr_o) mem[ram_addr_o[11:0]] = ram_dout_o;
  end

  typedef struct { int cyc; logic [31:0] addr; logic wr; logic [7:0] dout; } aph_t;
  typedef struct { int cyc; logic is_if; logic chk; logic [31:0] data; } done_t;
  aph_t  aq[$];
  done_t dq[$];
  aph_t  a;
  done_t d;

  logic [31:0] o_addr [16];
  logic        o_wr   [16];
  logic [7:0]  o_dout [16];
  logic        o_ifd  [16];
  logic        o_md   [16];
  logic [31:0] o_ifdata [16];
  logic [31:0] o_mdata  [16];
  logic [31:0] ea, obs;
  logic [7:0]  ed;
  logic        ew, eif, emd;

  task automatic exp_phases(input int c1, input logic [31:0] base, input int n,
                            input logic wr, input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      aq.push_back('{c1 + k, base + k, wr, wr ? wd[8*k +: 8] : 8'h00});
    end
  endtask

  task automatic exp_done(input int c, input logic is_if, input logic chk,
                          input logic [31:0] data);
    dq.push_back('{c, is_if, chk, data});
  endtask

  // Runs n cycles from cycle 0 (the current one), recording outputs at the
  // falling edge. Requesters drop req the cycle after done / flush / reset.
  task automatic cap(input int n, input int flush_cyc, input int rst_cyc);
    for (int i = 0; i < n; i++) begin
      if_flush_i = (i == flush_cyc);
      if (i == rst_cyc) rst = 1'b0;
      else if (i == rst_cyc + 1) rst = 1'b1;
      @(negedge clk);
      o_addr[i] = ram_addr_o; o_wr[i] = ram_wr_o; o_dout[i] = ram_dout_o;
      o_ifd[i] = if_done_o; o_md[i] = mem_done_o;
      o_ifdata[i] = if_data_o; o_mdata[i] = mem_rdata_o;
      @(posedge clk); #1;
      if (o_ifd[i] || i == flush_cyc || i == rst_cyc) if_req_i = 1'b0;
      if (o_md[i] || i == rst_cyc) mem_req_i = 1'b0;
    end
    if_flush_i = 1'b0;
    rst = 1'b1;
    mem_we_i = 1'b0; mem_len_i = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req_i = 0; if_flush_i = 0; mem_req_i = 0; mem_we_i = 0; mem_len_i = 0;
    if_addr_i = 0; mem_addr_i = 0; mem_wdata_i = 0; m2_req = 0; m2_addr = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_addr_o, ram_wr_o, ram_dout_o} !== 41'd0) begin
      errors++;
      $display("FAIL reset_ram got addr %h wr %b dout %h want 0", ram_addr_o, ram_wr_o, ram_dout_o);
    end
    checks++;
    if ({if_done_o, mem_done_o, if_data_o, mem_rdata_o} !== 66'd0) begin
      errors++;
      $display("FAIL reset_out got ifd %b md %b ifdata %h mdata %h want 0",
               if_done_o, mem_done_o, if_data_o, mem_rdata_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_fetch();
    mem[12'h100] = 8'h93; mem[12'h101] = 8'h00; mem[12'h102] = 8'hA0; mem[12'h103] = 8'h00;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    exp_phases(1, 32'h100, 4, 1'b0, 32'd0);
    exp_done(6, 1'b1, 1'b1, 32'h00A00093);
    cap(10, -5, -5);
    for (int i = 0; i < 10; i++) begin
      ea = '0; ew = 1'b0; ed = '0; eif = 1'b0; emd = 1'b0;
      if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; ew = a.wr; ed = a.dout; end
      checks++;
      if (o_addr[i] !== ea || o_wr[i] !== ew || o_dout[i] !== ed) begin
        errors++; $display("FAIL if_fetch_ram cyc %0d got %h/%b/%h want %h/%b/%h", i, o_addr[i], o_wr[i], o_dout[i], ea, ew, ed);
      end
      if (dq.size() != 0 && dq[0].cyc == i) begin
        d = dq.pop_front(); eif = d.is_if; emd = !d.is_if;
        obs = d.is_if ? o_ifdata[i] : o_mdata[i];
        checks++;
        if (d.chk && obs !== d.data) begin errors++; $display("FAIL if_fetch_data cyc %0d got %h want %h", i, obs, d.data); end
      end
      checks++;
      if (o_ifd[i] !== eif || o_md[i] !== emd) begin
        errors++; $display("FAIL if_fetch_done cyc %0d got if %b mem %b want if %b mem %b", i, o_ifd[i], o_md[i], eif, emd);
      end
    end
  endtask

  task automatic test_priority();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b00; mem_addr_i = 32'h20; mem_wdata_i = 32'h000000AB;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    exp_phases(1, 32'h20, 1, 1'b1, 32'h000000AB);
    exp_done(2, 1'b0, 1'b0, 32'd0);
    exp_phases(4, 32'h100, 4, 1'b0, 32'd0);
    exp_done(9, 1'b1, 1'b1, 32'h00A00093);
    cap(12, -5, -5);
    for (int i = 0; i < 12; i++) begin
      ea = '0; ew = 1'b0; ed = '0; eif = 1'b0; emd = 1'b0;
      if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; ew = a.wr; ed = a.dout; end
      checks++;
      if (o_addr[i] !== ea || o_wr[i] !== ew || o_dout[i] !== ed) begin
        errors++; $display("FAIL priority_ram cyc %0d got %h/%b/%h want %h/%b/%h", i, o_addr[i], o_wr[i], o_dout[i], ea, ew, ed);
      end
      if (dq.size() != 0 && dq[0].cyc == i) begin
        d = dq.pop_front(); eif = d.is_if; emd = !d.is_if;
        obs = d.is_if ? o_ifdata[i] : o_mdata[i];
        if (d.chk) begin
          checks++;
          if (obs !== d.data) begin errors++; $display("FAIL priority_data cyc %0d got %h want %h", i, obs, d.data); end
        end
      end
      checks++;
      if (o_ifd[i] !== eif || o_md[i] !== emd) begin
        errors++; $display("FAIL priority_done cyc %0d got if %b mem %b want if %b mem %b", i, o_ifd[i], o_md[i], eif, emd);
      end
    end
    checks++;
    if (mem[12'h020] !== 8'hAB) begin errors++; $display("FAIL priority_store got %h want ab", mem[12'h020]); end
  endtask

  task automatic test_load_half();
    mem[12'h1FE] = 8'h34; mem[12'h1FF] = 8'h12;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b01; mem_addr_i = 32'h1FE;
    exp_phases(1, 32'h1FE, 2, 1'b0, 32'd0);
    exp_done(4, 1'b0, 1'b1, 32'h00001234);
    cap(7, -5, -5);
    for (int i = 0; i < 7; i++) begin
      ea = '0; ew = 1'b0; ed = '0; eif = 1'b0; emd = 1'b0;
      if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; ew = a.wr; ed = a.dout; end
      checks++;
      if (o_addr[i] !== ea || o_wr[i] !== ew || o_dout[i] !== ed) begin
        errors++; $display("FAIL load_ram cyc %0d got %h/%b/%h want %h/%b/%h", i, o_addr[i], o_wr[i], o_dout[i], ea, ew, ed);
      end
      if (dq.size() != 0 && dq[0].cyc == i) begin
        d = dq.pop_front(); eif = d.is_if; emd = !d.is_if;
        checks++;
        if (o_mdata[i] !== d.data) begin errors++; $display("FAIL load_data cyc %0d got %h want %h", i, o_mdata[i], d.data); end
      end
      checks++;
      if (o_ifd[i] !== eif || o_md[i] !== emd) begin
        errors++; $display("FAIL load_done cyc %0d got if %b mem %b want if %b mem %b", i, o_ifd[i], o_md[i], eif, emd);
      end
    end
    // same half-word load on the RD_LAT=2 instance
    m2_req = 1'b1; m2_addr = 32'h1FE;
    exp_phases(1, 32'h1FE, 2, 1'b0, 32'd0);
    exp_done(5, 1'b0, 1'b1, 32'h00001234);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      o_addr[i] = d2_addr; o_md[i] = d2_mdone; o_mdata[i] = d2_mrdata;
      @(posedge clk); #1;
      if (o_md[i]) m2_req = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      ea = '0; emd = 1'b0;
      if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; end
      checks++;
      if (o_addr[i] !== ea) begin errors++; $display("FAIL lat2_addr cyc %0d got %h want %h", i, o_addr[i], ea); end
      if (dq.size() != 0 && dq[0].cyc == i) begin
        d = dq.pop_front(); emd = 1'b1;
        checks++;
        if (o_mdata[i] !== d.data) begin errors++; $display("FAIL lat2_data cyc %0d got %h want %h", i, o_mdata[i], d.data); end
      end
      checks++;
      if (o_md[i] !== emd) begin errors++; $display("FAIL lat2_done cyc %0d got %b want %b", i, o_md[i], emd); end
    end
  endtask

  task automatic test_flush();
    mem[12'h180] = 8'h11; mem[12'h181] = 8'h22; mem[12'h182] = 8'h33; mem[12'h183] = 8'h44;
    mem[12'h200] = 8'h55; mem[12'h201] = 8'h66; mem[12'h202] = 8'h77; mem[12'h203] = 8'h88;
    for (int pass = 0; pass < 2; pass++) begin
      if_req_i = 1'b1;
      if (pass == 0) begin
        if_addr_i = 32'h180;
        exp_phases(1, 32'h180, 3, 1'b0, 32'd0);
        cap(9, 3, -5);
      end else begin
        if_addr_i = 32'h200;
        exp_phases(1, 32'h200, 4, 1'b0, 32'd0);
        exp_done(6, 1'b1, 1'b1, 32'h88776655);
        cap(9, -5, -5);
      end
      for (int i = 0; i < 9; i++) begin
        ea = '0; ew = 1'b0; ed = '0; eif = 1'b0; emd = 1'b0;
        if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; ew = a.wr; ed = a.dout; end
        checks++;
        if (o_addr[i] !== ea || o_wr[i] !== ew || o_dout[i] !== ed) begin
          errors++; $display("FAIL flush%0d_ram cyc %0d got %h/%b/%h want %h/%b/%h", pass, i, o_addr[i], o_wr[i], o_dout[i], ea, ew, ed);
        end
        if (dq.size() != 0 && dq[0].cyc == i) begin
          d = dq.pop_front(); eif = 1'b1;
          checks++;
          if (o_ifdata[i] !== d.data) begin errors++; $display("FAIL flush%0d_data cyc %0d got %h want %h", pass, i, o_ifdata[i], d.data); end
        end
        checks++;
        if (o_ifd[i] !== eif || o_md[i] !== emd) begin
          errors++; $display("FAIL flush%0d_done cyc %0d got if %b mem %b want if %b mem %b", pass, i, o_ifd[i], o_md[i], eif, emd);
        end
      end
      if (pass == 0) begin
        checks++;
        if (o_ifdata[8] !== 32'h00A00093) begin errors++; $display("FAIL flush_hold got %h want 00a00093", o_ifdata[8]); end
      end
    end
  endtask

  task automatic test_wrap();
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hD4;
    if_req_i = 1'b1; if_addr_i = 32'hFFFFFFFE;
    exp_phases(1, 32'hFFFFFFFE, 4, 1'b0, 32'd0);
    exp_done(6, 1'b1, 1'b1, 32'hD4C3B2A1);
    cap(8, -5, -5);
    for (int i = 0; i < 8; i++) begin
      ea = '0; eif = 1'b0;
      if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; end
      checks++;
      if (o_addr[i] !== ea || o_wr[i] !== 1'b0) begin
        errors++; $display("FAIL wrap_addr cyc %0d got %h wr %b want %h wr 0", i, o_addr[i], o_wr[i], ea);
      end
      if (dq.size() != 0 && dq[0].cyc == i) begin
        d = dq.pop_front(); eif = 1'b1;
        checks++;
        if (o_ifdata[i] !== d.data) begin errors++; $display("FAIL wrap_data cyc %0d got %h want %h", i, o_ifdata[i], d.data); end
      end
      checks++;
      if (o_ifd[i] !== eif || o_md[i] !== 1'b0) begin
        errors++; $display("FAIL wrap_done cyc %0d got if %b mem %b want if %b mem 0", i, o_ifd[i], o_md[i], eif);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) mem[12'h300 + k] = 8'hEE;
    for (int pass = 0; pass < 2; pass++) begin
      mem_req_i = 1'b1; mem_we_i = 1'b1;
      if (pass == 0) begin
        mem_len_i = 2'b10; mem_addr_i = 32'h300; mem_wdata_i = 32'h44332211;
        exp_phases(1, 32'h300, 1, 1'b1, 32'h44332211);
        cap(6, -5, 2);
      end else begin
        mem_len_i = 2'b11; mem_addr_i = 32'h310; mem_wdata_i = 32'hDDCCBBAA;
        exp_phases(1, 32'h310, 4, 1'b1, 32'hDDCCBBAA);
        exp_done(5, 1'b0, 1'b0, 32'd0);
        cap(8, -5, -5);
      end
      for (int i = 0; i < (pass == 0 ? 6 : 8); i++) begin
        ea = '0; ew = 1'b0; ed = '0; emd = 1'b0;
        if (aq.size() != 0 && aq[0].cyc == i) begin a = aq.pop_front(); ea = a.addr; ew = a.wr; ed = a.dout; end
        if (dq.size() != 0 && dq[0].cyc == i) begin d = dq.pop_front(); emd = 1'b1; end
        checks++;
        if (o_addr[i] !== ea || o_wr[i] !== ew || o_dout[i] !== ed) begin
          errors++; $display("FAIL rstmid%0d_ram cyc %0d got %h/%b/%h want %h/%b/%h", pass, i, o_addr[i], o_wr[i], o_dout[i], ea, ew, ed);
        end
        checks++;
        if (o_md[i] !== emd || o_ifd[i] !== 1'b0) begin
          errors++; $display("FAIL rstmid%0d_done cyc %0d got mem %b if %b want mem %b if 0", pass, i, o_md[i], o_ifd[i], emd);
        end
      end
    end
    checks++;
    if ({mem[12'h301], mem[12'h300]} !== 16'hEE11) begin
      errors++; $display("FAIL rstmid_kept got %h%h want ee11", mem[12'h301], mem[12'h300]);
    end
    checks++;
    if ({mem[12'h313], mem[12'h312], mem[12'h311], mem[12'h310]} !== 32'hDDCCBBAA) begin
      errors++; $display("FAIL rstmid_store got %h%h%h%h want ddccbbaa", mem[12'h313], mem[12'h312], mem[12'h311], mem[12'h310]);
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_priority();
    test_load_half();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
